// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: valid/ready command sequencer for the 4-bit registered ALU.
// It latches one command, drives the ALU pins, waits ALU_LAT edges and then
// captures the masked result and flags. It holds the response until the host
// consumes it.
// Optional build macro ALU_DRV_CHECK_EN adds a golden-model checker. This
// checker drives a sticky err_mismatch output. Without the macro, err_mismatch
// is tied to 0.
module alu_cmd_driver #(
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [2:0]       cmd_op,
  output logic [7:0]       alu_ui_in,
  output logic [7:0]       alu_uio_in,
  input  logic [7:0]       alu_uo_out,
  input  logic [7:0]       alu_uio_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_carry,
  output logic             rsp_overflow,
  output logic [2:0]       rsp_op,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count,
  output logic             err_mismatch
);

  localparam int WCNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, CAPT, RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WCNT_W-1:0] wait_cnt;
  logic [2:0]        lat_op;
  logic              unused_flags;

  assign lat_op       = alu_uio_in[2:0];
  assign unused_flags = ^alu_uio_out[5:0];

  // Upper nibble is stale for ADD/SUB. The flags are stale for every other op.
  // Packed as {result[7:0], carry, overflow}.
  function automatic logic [9:0] mask_rsp(input logic [2:0] op, input logic [7:0] res,
                                          input logic c, input logic v);
    if (op < 3'd2) mask_rsp = {4'h0, res[3:0], c, v};
    else           mask_rsp = {res, 2'b00};
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: one command in flight, IDLE -> WAIT -> CAPT -> RESP
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_valid) state_nxt = WAIT;
      WAIT: if (wait_cnt == WCNT_W'(ALU_LAT - 1)) state_nxt = CAPT;
      CAPT: state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);

  // Command latch, wait counter, response capture and transaction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ui_in    <= '0;
      alu_uio_in   <= '0;
      wait_cnt     <= '0;
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_op       <= '0;
      txn_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            alu_ui_in  <= {cmd_a, cmd_b};
            alu_uio_in <= {5'b0, cmd_op};
            wait_cnt   <= '0;
          end
        end
        WAIT: wait_cnt <= wait_cnt + 1'b1;
        CAPT: begin
          {rsp_result, rsp_carry, rsp_overflow} <=
            mask_rsp(lat_op, alu_uo_out, alu_uio_out[6], alu_uio_out[7]);
          rsp_op <= lat_op;
        end
        RESP: if (rsp_ready) txn_count <= txn_count + 1'b1;
        default: ;
      endcase
    end
  end

`ifdef ALU_DRV_CHECK_EN
  logic err_q;

  // Reference ALU behaviour. Packed as {result[7:0], carry, overflow}.
  function automatic logic [9:0] golden(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] op);
    logic signed [4:0] sa;
    logic signed [4:0] sb;
    logic signed [4:0] ss;
    logic        [4:0] us;
    logic        [7:0] prod;
    sa     = {a[3], a};
    sb     = {b[3], b};
    ss     = '0;
    us     = '0;
    prod   = {4'h0, a} * {4'h0, b};
    golden = '0;
    case (op)
      3'd0: begin
        us     = {1'b0, a} + {1'b0, b};
        ss     = sa + sb;
        golden = {4'h0, us[3:0], us[4], ss[4] ^ ss[3]};
      end
      3'd1: begin
        us     = {1'b0, a} - {1'b0, b};
        ss     = sa - sb;
        golden = {4'h0, us[3:0], ~us[4], ss[4] ^ ss[3]};
      end
      3'd2: golden = {prod, 2'b00};
      3'd3: golden = (b == 4'h0) ? 10'h000 : {a % b, a / b, 2'b00};
      3'd4: golden = {4'h0, a & b, 2'b00};
      3'd5: golden = {4'h0, a | b, 2'b00};
      3'd6: golden = {4'h0, a ^ b, 2'b00};
      default: golden = {4'h0, ~a, 2'b00};
    endcase
  endfunction

  // Sticky flag: captured response disagrees with the reference model
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (state == CAPT) begin
      if (mask_rsp(lat_op, alu_uo_out, alu_uio_out[6], alu_uio_out[7]) !=
          golden(alu_ui_in[7:4], alu_ui_in[3:0], lat_op))
        err_q <= 1'b1;
    end
  end

  assign err_mismatch = err_q;
`else
  assign err_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: directed bench for alu_cmd_driver with a behavioural
// one-cycle registered ALU and a response scoreboard.
module tb_alu_cmd_driver;
  localparam int ALU_LAT = 1;
  localparam int CNT_W   = 8;
`ifdef ALU_DRV_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_a;
  logic [3:0]       cmd_b;
  logic [2:0]       cmd_op;
  logic [7:0]       alu_ui_in;
  logic [7:0]       alu_uio_in;
  logic [7:0]       alu_uo_out;
  logic [7:0]       alu_uio_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_result;
  logic             rsp_carry;
  logic             rsp_overflow;
  logic [2:0]       rsp_op;
  logic             busy;
  logic [CNT_W-1:0] txn_count;
  logic             err_mismatch;

  alu_cmd_driver #(.ALU_LAT(ALU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_ui_in(alu_ui_in), .alu_uio_in(alu_uio_in),
    .alu_uo_out(alu_uo_out), .alu_uio_out(alu_uio_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .rsp_overflow(rsp_overflow), .rsp_op(rsp_op),
    .busy(busy), .txn_count(txn_count), .err_mismatch(err_mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: inputs registered once, stale nibble/flags driven as junk
  logic [7:0] alu_a_q;
  logic [7:0] alu_o_q;
  logic       corrupt;
  logic [7:0] alu_res;
  logic [7:0] alu_flg;

  always @(posedge clk) begin
    alu_a_q <= alu_ui_in;
    alu_o_q <= alu_uio_in;
  end

  always_comb begin
    logic [3:0] ta;
    logic [3:0] tb;
    logic [4:0] s;
    ta      = alu_a_q[7:4];
    tb      = alu_a_q[3:0];
    s       = '0;
    alu_res = 8'h00;
    alu_flg = 8'hC0;
    case (alu_o_q[2:0])
      3'd0: begin
        s       = {1'b0, ta} + {1'b0, tb};
        alu_res = {4'h5, s[3:0]};
        alu_flg = {(ta[3] == tb[3]) && (s[3] != ta[3]), s[4], 6'h2A};
      end
      3'd1: begin
        s       = {1'b0, ta} - {1'b0, tb};
        alu_res = {4'h5, s[3:0]};
        alu_flg = {(ta[3] != tb[3]) && (s[3] != ta[3]), ~s[4], 6'h15};
      end
      3'd2: alu_res = {4'h0, ta} * {4'h0, tb};
      3'd3: alu_res = (tb == 4'h0) ? 8'h00 : {ta % tb, ta / tb};
      3'd4: alu_res = {4'h0, ta & tb};
      3'd5: alu_res = {4'h0, ta | tb};
      3'd6: alu_res = {4'h0, ta ^ tb};
      default: alu_res = {4'h0, ~ta};
    endcase
  end

  assign alu_uo_out  = alu_res | {7'b0, corrupt};
  assign alu_uio_out = alu_flg;

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       v;
    logic [2:0] op;
  } exp_t;

  exp_t       sb[$];
  int         chk_n   = 0;
  int         err_n   = 0;
  int         exp_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] r, input logic c, input logic v, input logic [2:0] op);
    exp_t e;
    e.res = r; e.c = c; e.v = v; e.op = op;
    sb.push_back(e);
  endtask

  // Present a command and return just after the accepting edge
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic done;
    done = 1'b0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (cmd_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!rsp_valid) check("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_result"}, rsp_result, e.res);
      check({tag, "_carry"}, rsp_carry, e.c);
      check({tag, "_ovf"}, rsp_overflow, e.v);
      check({tag, "_op"}, rsp_op, e.op);
    end
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_cnt++;
    check({tag, "_valid_drop"}, rsp_valid, 1'b0);
    check({tag, "_txn_count"}, txn_count, exp_cnt);
  endtask

  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] op, input logic [7:0] r, input logic c, input logic v);
    int cyc;
    push(r, c, v, op);
    issue(a, b, op);
    wait_rsp(cyc);
    check({tag, "_latency"}, cyc, ALU_LAT + 1);
    pop_check(tag);
    handshake(tag);
  endtask

  initial begin
    int         cyc;
    logic [7:0] held_res;
    logic       seen;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    rsp_ready = 1'b0; corrupt = 1'b0;
    #12;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_ui_in", alu_ui_in, 8'h00);
    check("rst_uio_in", alu_uio_in, 8'h00);
    check("rst_result", rsp_result, 8'h00);
    check("rst_txn", txn_count, 0);
    check("rst_err", err_mismatch, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op("add_7_9",  4'd7,  4'd9,  3'd0, 8'h00, 1'b1, 1'b0);
    run_op("sub_3_5",  4'd3,  4'd5,  3'd1, 8'h0E, 1'b0, 1'b0);
    run_op("mul_f_f",  4'd15, 4'd15, 3'd2, 8'hE1, 1'b0, 1'b0);
    run_op("div_13_4", 4'd13, 4'd4,  3'd3, 8'h13, 1'b0, 1'b0);
    run_op("div_9_0",  4'd9,  4'd0,  3'd3, 8'h00, 1'b0, 1'b0);
    run_op("not_5",    4'd5,  4'd3,  3'd7, 8'h0A, 1'b0, 1'b0);
    run_op("add_ovf",  4'd7,  4'd1,  3'd0, 8'h08, 1'b0, 1'b1);
    run_op("sub_ovf",  4'd8,  4'd1,  3'd1, 8'h07, 1'b1, 1'b1);
    run_op("xor_c_a",  4'hC,  4'hA,  3'd6, 8'h06, 1'b0, 1'b0);
    check("good_ops_err", err_mismatch, 1'b0);

    // Backpressure with a second command waiting
    push(8'h08, 1'b0, 1'b0, 3'd4);
    issue(4'hC, 4'hA, 3'd4);
    wait_rsp(cyc);
    held_res = rsp_result;
    check("bp_first_result", held_res, 8'h08);
    push(8'h0E, 1'b0, 1'b0, 3'd5);
    cmd_a = 4'hC; cmd_b = 4'hA; cmd_op = 3'd5; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_valid_held", rsp_valid, 1'b1);
      check("bp_result_held", rsp_result, held_res);
      check("bp_cmd_ready", cmd_ready, 1'b0);
      check("bp_ui_in_held", alu_ui_in, 8'hCA);
    end
    pop_check("bp_and");
    handshake("bp_and");
    check("bp_idle_ready", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("bp_second_accept", cmd_ready, 1'b0);
    check("bp_second_op", alu_uio_in, 8'h05);
    wait_rsp(cyc);
    check("bp_or_latency", cyc, ALU_LAT + 1);
    pop_check("bp_or");
    handshake("bp_or");
    @(posedge clk); #1;
    check("inputs_hold_after_rsp", alu_ui_in, 8'hCA);

    // Reset while the command is in WAIT
    issue(4'd2, 4'd3, 3'd0);
    check("mid_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", cmd_ready, 1'b1);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", rsp_valid, 1'b0);
    check("mid_rst_ui", alu_ui_in, 8'h00);
    check("mid_rst_uio", alu_uio_in, 8'h00);
    check("mid_rst_txn", txn_count, 0);
    exp_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    check("mid_no_rsp", seen, 1'b0);
    run_op("post_rst_add", 4'd1, 4'd2, 3'd0, 8'h03, 1'b0, 1'b0);

    // Corrupted ALU result bit0 during ADD 1+1
    corrupt = 1'b1;
    run_op("corrupt_add", 4'd1, 4'd1, 3'd0, 8'h03, 1'b0, 1'b0);
    corrupt = 1'b0;
    check("err_set", err_mismatch, EXP_ERR);
    run_op("after_err", 4'd6, 4'd2, 3'd5, 8'h06, 1'b0, 1'b0);
    check("err_sticky", err_mismatch, EXP_ERR);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", chk_n, err_n);
    $finish;
  end

endmodule
